ring_bus_arbiter: RTL

//  Round-robin arbiter sharing the three-net buffer ring (a/b/c) among NUM_REQ BLK stages.

---
 rtl/ring_arb_pkg.sv | 9 +
 rtl/ring_bus_arbiter_rr_pick.sv | 23 ++
 rtl/ring_bus_arbiter.sv | 83 ++++++++
 3 files changed

// File: rtl/ring_arb_pkg.sv
// ring_arb_pkg: shared state encoding, counter widths and index-width helper for the ring bus arbiter.
package ring_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;
  localparam int HOLD_W = 8;
  localparam int TURN_W = 3;
  function automatic int idx_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ring_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick, first set req bit searching upward from ptr+1 with wrap.
module rr_pick #(
  parameter int N = 20,
  parameter int W = 5
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);
  int j;
  // Scan farthest-first so the nearest hit after ptr is the last one written.
  always_comb begin
    valid = |req;
    idx = '0;
    j = 0;
    for (int k = N; k >= 1; k--) begin
      j = int'(ptr) + k;
      j = j >= N ? j - N : j;
      if (req[j]) idx = W'(j);
    end
  end
endmodule

// File: rtl/ring_bus_arbiter.sv
// ring_bus_arbiter: round-robin ring owner arbiter with hold limit and turnaround gap.
// Optional RING_ARB_STATS_EN adds saturating grant_cnt / revoke_cnt ports.
module ring_bus_arbiter
  import ring_arb_pkg::*;
#(
  parameter int NUM_REQ  = 20,
  parameter int MAX_HOLD = 8,
  parameter int TURN_CYC = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          done,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [idx_w(NUM_REQ)-1:0]   gnt_idx,
  output logic                        busy,
  output logic                        drive_en
`ifdef RING_ARB_STATS_EN
  ,
  output logic [15:0]                 grant_cnt,
  output logic [15:0]                 revoke_cnt
`endif
);
  localparam int W = idx_w(NUM_REQ);
  if (NUM_REQ < 2 || NUM_REQ > 32 || MAX_HOLD < 1 || MAX_HOLD > 255 || TURN_CYC < 1 || TURN_CYC > 7) begin : g_bad_param
    $error("ring_bus_arbiter: parameter out of range");
  end
  state_t state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [TURN_W-1:0] turn_cnt;
  logic [W-1:0] ptr, win;
  logic any, forced, rel;
  rr_pick #(.N(NUM_REQ), .W(W)) u_pick (.req(req), .ptr(ptr), .valid(any), .idx(win));
  assign forced = hold_cnt == HOLD_W'(MAX_HOLD);
  assign rel = done[gnt_idx] | ~req[gnt_idx] | forced;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      gnt_idx <= '0;
      busy <= 1'b0;
      drive_en <= 1'b0;
      hold_cnt <= '0;
      turn_cnt <= '0;
      ptr <= W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: if (any) begin
          gnt <= NUM_REQ'(1) << win;
          gnt_idx <= win;
          ptr <= win;
          hold_cnt <= HOLD_W'(1);
          busy <= 1'b1;
          drive_en <= 1'b1;
          state <= GRANT;
        end
        GRANT: if (rel) begin
          gnt <= '0;
          gnt_idx <= '0;
          drive_en <= 1'b0;
          turn_cnt <= TURN_W'(1);
          state <= TURN;
        end else hold_cnt <= hold_cnt + HOLD_W'(1);
        TURN: if (turn_cnt == TURN_W'(TURN_CYC)) begin
          busy <= 1'b0;
          state <= IDLE;
        end else turn_cnt <= turn_cnt + TURN_W'(1);
        default: state <= IDLE;
      endcase
    end
  end
`ifdef RING_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
      revoke_cnt <= '0;
    end else begin
      if (state == IDLE && any && grant_cnt != 16'hFFFF) grant_cnt <= grant_cnt + 16'd1;
      if (state == GRANT && forced && revoke_cnt != 16'hFFFF) revoke_cnt <= revoke_cnt + 16'd1;
    end
  end
`endif
endmodule
